writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter: RETIRE_W, 32, width of the retired-instruction counter.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 v_i  input  1  EX result valid.
REQ-005 stall_o  output  1  holds EX; EX must keep v_i/wb_i/rd_num_i/rd_data_i stable while high.
REQ-006 wb_i  input  1  result must be written to the register file.
REQ-007 rd_num_i  input  `W_RD  destination register number.
REQ-008 rd_data_i  input  `WORD  destination data.
REQ-009 rs1_num_i, rs2_num_i  input  `W_RD  ID read-port register numbers.
REQ-010 rs1_data_o, rs2_data_o  output  `WORD  ID read-port data, combinational.
REQ-011 dbg_we_i  input  1  debug write request, single-cycle pulse per write.
REQ-012 dbg_num_i  input  `W_RD  debug write register number.
REQ-013 dbg_data_i  input  `WORD  debug write data.
REQ-014 retired_o  output  RETIRE_W  count of accepted EX results.

Function
REQ-015 The register file SHALL hold 2^`W_RD entries of `WORD bits; entry 0 SHALL always read 0 and ignore writes.
REQ-016 An EX result is accepted in a cycle when v_i=1 and stall_o=0.
REQ-017 stall_o SHALL be dbg_we_i & v_i & wb_i, combinational; no other stall source.
REQ-018 Debug write SHALL have priority: when dbg_we_i=1, entry dbg_num_i is written with dbg_data_i at the next edge.
REQ-019 An accepted result with wb_i=1 SHALL write rd_data_i to entry rd_num_i at the next edge (1-cycle write latency).
REQ-020 An accepted result with wb_i=0 SHALL not modify the register file.
REQ-021 At most one register-file write per cycle; simultaneous EX and debug write SHALL resolve by stalling EX one cycle, then EX writes the following cycle if dbg_we_i is low.
REQ-022 Read data for each port SHALL be selected in priority order: number 0 -> 0; accepted EX write (wb_i=1) to same number -> rd_data_i; dbg_we_i to same number -> dbg_data_i; else stored entry.
REQ-023 Bypass SHALL not use rd_data_i when stall_o=1 or v_i=0.
REQ-024 retired_o SHALL increment by 1 per accepted result (wb_i 0 or 1) and wrap from all-ones to 0.
REQ-025 stall_o SHALL be 0 whenever v_i=0, regardless of dbg_we_i.

Reset
REQ-026 On rst low, all register-file entries and retired_o SHALL become 0 immediately, independent of clk.
REQ-027 stall_o and read outputs SHALL follow their combinational definitions during reset (reads return 0).
REQ-028 Writes presented on the edge at which rst deasserts are not required to take effect; writes on later edges SHALL.

Structure
REQ-029 `WORD (32) and `W_RD (5) SHALL come from the shared include/params.vh; no local redefinition.
REQ-030 One sub-module, regfile, SHALL contain storage, reset and one write port; writeback SHALL hold arbitration, bypass, stall and counter.

Verification
REQ-031 Reset, then read r1..r31 -> all 0; retired_o=0.
REQ-032 v_i=1,wb_i=1,rd_num_i=5,rd_data_i=0xDEADBEEF, rs1_num_i=5 same cycle -> rs1_data_o=0xDEADBEEF that cycle, entry 5 holds it next cycle, retired_o=1.
REQ-033 Write rd_num_i=0 data 0x1234 -> rs1 with num 0 reads 0 before and after; retired_o increments.
REQ-034 dbg_we_i=1 (r7=0xA5A5A5A5) with v_i=1,wb_i=1,rd_num_i=7 (0x11111111) -> stall_o=1, r7=0xA5A5A5A5 after edge, retired_o unchanged; next cycle with dbg_we_i=0 -> stall_o=0, r7=0x11111111, retired_o+1.
REQ-035 Preload retired_o to 0xFFFFFFFF via 2^32-1 accepts (or forced) then one accept with wb_i=0 -> retired_o=0, register file unchanged.
REQ-036 Assert rst low mid-stream after writing r3=0x55 -> r3 reads 0 immediately, retired_o=0.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared widths, write-port record and read-bypass helper for the writeback stage.
package writeback_pkg;

    localparam int WORD   = 32;
    localparam int W_RD   = 5;
    localparam int N_REGS = 1 << W_RD;

    typedef logic [WORD-1:0] word_t;
    typedef logic [W_RD-1:0] reg_num_t;

    typedef struct packed {
        logic     we;
        reg_num_t num;
        word_t    data;
    } rf_wr_t;

    // Register 0 reads as zero; an EX write beats a debug write when both target the port's number.
    function automatic word_t bypass(input reg_num_t num, input rf_wr_t ex_wr,
                                     input rf_wr_t dbg_wr, input word_t stored);
        word_t res;
        if (num == '0)
            res = '0;
        else if (ex_wr.we && ex_wr.num == num)
            res = ex_wr.data;
        else if (dbg_wr.we && dbg_wr.num == num)
            res = dbg_wr.data;
        else
            res = stored;
        return res;
    endfunction

endpackage

// File: rtl/writeback_if.sv
// EX result, ID read-port and debug-write signals between the pipeline and writeback.
interface writeback_if;
    import writeback_pkg::*;

    logic     v_i;
    logic     stall_o;
    logic     wb_i;
    reg_num_t rd_num_i;
    word_t    rd_data_i;
    reg_num_t rs1_num_i;
    reg_num_t rs2_num_i;
    word_t    rs1_data_o;
    word_t    rs2_data_o;
    logic     dbg_we_i;
    reg_num_t dbg_num_i;
    word_t    dbg_data_i;

    modport master (
        output v_i, wb_i, rd_num_i, rd_data_i, rs1_num_i, rs2_num_i,
               dbg_we_i, dbg_num_i, dbg_data_i,
        input  stall_o, rs1_data_o, rs2_data_o
    );

    modport slave (
        input  v_i, wb_i, rd_num_i, rd_data_i, rs1_num_i, rs2_num_i,
               dbg_we_i, dbg_num_i, dbg_data_i,
        output stall_o, rs1_data_o, rs2_data_o
    );

endinterface

// File: rtl/writeback_regfile.sv
// Register storage: one write port (1-cycle), two combinational reads, async active-low clear.
// Entry 0 is never written, so it always reads zero.
module regfile
    import writeback_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  rf_wr_t   wr,
    input  reg_num_t rs1_num,
    input  reg_num_t rs2_num,
    output word_t    rs1_data,
    output word_t    rs2_data
);

    word_t mem [N_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REGS; i++)
                mem[i] <= '0;
        end else if (wr.we && wr.num != '0) begin
            mem[wr.num] <= wr.data;
        end
    end

    assign rs1_data = mem[rs1_num];
    assign rs2_data = mem[rs2_num];

endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates EX vs debug writes, bypasses reads, counts retired results.
// EX is stalled for one cycle whenever a debug write collides with an EX write; reads are combinational.
module writeback
    import writeback_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    writeback_if.slave          bus,
    output logic [RETIRE_W-1:0] retired_o
);

    logic   stall;
    logic   accept;
    rf_wr_t ex_wr;
    rf_wr_t dbg_wr;
    rf_wr_t rf_wr;
    word_t  rs1_stored;
    word_t  rs2_stored;

    // Only one register-file write port, so a debug write pushes a writing EX result back a cycle.
    always_comb begin
        stall       = bus.dbg_we_i & bus.v_i & bus.wb_i;
        accept      = bus.v_i & ~stall;
        ex_wr.we    = accept & bus.wb_i;
        ex_wr.num   = bus.rd_num_i;
        ex_wr.data  = bus.rd_data_i;
        dbg_wr.we   = bus.dbg_we_i;
        dbg_wr.num  = bus.dbg_num_i;
        dbg_wr.data = bus.dbg_data_i;
        rf_wr       = dbg_wr.we ? dbg_wr : ex_wr;
    end

    regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr       (rf_wr),
        .rs1_num  (bus.rs1_num_i),
        .rs2_num  (bus.rs2_num_i),
        .rs1_data (rs1_stored),
        .rs2_data (rs2_stored)
    );

    assign bus.stall_o    = stall;
    assign bus.rs1_data_o = bypass(bus.rs1_num_i, ex_wr, dbg_wr, rs1_stored);
    assign bus.rs2_data_o = bypass(bus.rs2_num_i, ex_wr, dbg_wr, rs2_stored);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retired_o <= '0;
        else if (accept)
            retired_o <= retired_o + 1'b1;
    end

endmodule

// File: tb/tb_writeback.sv
// Directed vector table plus hand-written reset and counter-wrap sequences for writeback.
module tb_writeback;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [31:0] retired;
    logic [3:0]  retired2;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    writeback_if bus ();
    writeback_if bus2 ();

    writeback #(.RETIRE_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .retired_o (retired)
    );

    // Narrow counter instance so the wrap from all-ones is reachable in a few cycles.
    writeback #(.RETIRE_W(4)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .retired_o (retired2)
    );

    typedef struct {
        logic        v;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        dwe;
        logic [4:0]  dnum;
        logic [31:0] ddata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_stall;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_ret;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    function automatic vec_t mk(logic v, logic wb, logic [4:0] rd, logic [31:0] rd_data,
                                logic dwe, logic [4:0] dnum, logic [31:0] ddata,
                                logic [4:0] rs1, logic [4:0] rs2, logic e_stall,
                                logic [31:0] e_rs1, logic [31:0] e_rs2, logic [31:0] e_ret);
        vec_t t;
        t.v = v; t.wb = wb; t.rd = rd; t.rd_data = rd_data;
        t.dwe = dwe; t.dnum = dnum; t.ddata = ddata;
        t.rs1 = rs1; t.rs2 = rs2; t.e_stall = e_stall;
        t.e_rs1 = e_rs1; t.e_rs2 = e_rs2; t.e_ret = e_ret;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.v_i = 0; bus.wb_i = 0; bus.rd_num_i = 0; bus.rd_data_i = 0;
        bus.dbg_we_i = 0; bus.dbg_num_i = 0; bus.dbg_data_i = 0;
    endtask

    initial begin
        drive_idle();
        bus.rs1_num_i = 0; bus.rs2_num_i = 0;
        bus2.v_i = 0; bus2.wb_i = 0; bus2.rd_num_i = 0; bus2.rd_data_i = 0;
        bus2.rs1_num_i = 0; bus2.rs2_num_i = 0;
        bus2.dbg_we_i = 0; bus2.dbg_num_i = 0; bus2.dbg_data_i = 0;

        //          v  wb rd  rd_data        dwe dn  ddata          rs1 rs2 stl e_rs1          e_rs2          ret
        tbl[0]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,         5,  0, 0, 32'hDEADBEEF, 32'h0,         1);
        tbl[1]  = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,         5,  6, 0, 32'hDEADBEEF, 32'h0,         1);
        tbl[2]  = mk(1, 1, 0, 32'h1234,     0, 0,  32'h0,         0,  5, 0, 32'h0,        32'hDEADBEEF, 2);
        tbl[3]  = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,         0,  0, 0, 32'h0,        32'h0,         2);
        tbl[4]  = mk(1, 0, 5, 32'hCAFEF00D, 0, 0,  32'h0,         5,  5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 3);
        tbl[5]  = mk(0, 1, 6, 32'h66,       0, 0,  32'h0,         6,  0, 0, 32'h0,        32'h0,         3);
        tbl[6]  = mk(0, 1, 6, 32'h66,       1, 9,  32'h99,        9,  6, 0, 32'h99,       32'h0,         3);
        tbl[7]  = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,         9,  6, 0, 32'h99,       32'h0,         3);
        tbl[8]  = mk(1, 0, 4, 32'h44,       1, 10, 32'hAA,        10, 4, 0, 32'hAA,       32'h0,         4);
        tbl[9]  = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,         10, 5, 0, 32'hAA,       32'hDEADBEEF, 4);
        tbl[10] = mk(1, 1, 11, 32'hB,       0, 0,  32'h0,         11, 11, 0, 32'hB,       32'hB,         5);
        tbl[11] = mk(1, 1, 7, 32'h11111111, 1, 7,  32'hA5A5A5A5,  7,  0, 1, 32'hA5A5A5A5, 32'h0,         5);
        tbl[12] = mk(1, 1, 7, 32'h11111111, 0, 0,  32'h0,         7,  5, 0, 32'h11111111, 32'hDEADBEEF, 6);
        tbl[13] = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,         7,  11, 0, 32'h11111111, 32'hB,        6);
        tbl[14] = mk(1, 1, 13, 32'hD,       1, 12, 32'hC,         12, 13, 1, 32'hC,       32'h0,         6);
        tbl[15] = mk(1, 1, 13, 32'hD,       0, 0,  32'h0,         12, 13, 0, 32'hC,       32'hD,         7);
        tbl[16] = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,         13, 12, 0, 32'hD,       32'hC,         7);
        tbl[17] = mk(0, 0, 0, 32'h0,        1, 0,  32'hFFFF,      0,  0, 0, 32'h0,        32'h0,         7);
        tbl[18] = mk(0, 0, 0, 32'h0,        0, 0,  32'h0,         0,  9, 0, 32'h0,        32'h99,        7);
        tbl[19] = mk(1, 1, 3, 32'h55,       0, 0,  32'h0,         3,  0, 0, 32'h55,       32'h0,         8);

        // Reset state
        #2;
        chk("reset_retired", {32'h0, retired}, 64'h0);
        chk("reset_stall_idle", {63'h0, bus.stall_o}, 64'h0);
        #10 rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i < 32; i++) begin
            bus.rs1_num_i = 5'(i);
            bus.rs2_num_i = 5'(31 - i + 1);
            #1;
            chk($sformatf("init_rs1_r%0d", i), {32'h0, bus.rs1_data_o}, 64'h0);
            chk($sformatf("init_rs2_r%0d", 32 - i), {32'h0, bus.rs2_data_o}, 64'h0);
        end
        chk("init_retired", {32'h0, retired}, 64'h0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            bus.v_i = tbl[i].v; bus.wb_i = tbl[i].wb;
            bus.rd_num_i = tbl[i].rd; bus.rd_data_i = tbl[i].rd_data;
            bus.dbg_we_i = tbl[i].dwe; bus.dbg_num_i = tbl[i].dnum; bus.dbg_data_i = tbl[i].ddata;
            bus.rs1_num_i = tbl[i].rs1; bus.rs2_num_i = tbl[i].rs2;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), {63'h0, bus.stall_o}, {63'h0, tbl[i].e_stall});
            chk($sformatf("v%0d_rs1", i), {32'h0, bus.rs1_data_o}, {32'h0, tbl[i].e_rs1});
            chk($sformatf("v%0d_rs2", i), {32'h0, bus.rs2_data_o}, {32'h0, tbl[i].e_rs2});
            @(posedge clk); #1;
            chk($sformatf("v%0d_retired", i), {32'h0, retired}, {32'h0, tbl[i].e_ret});
        end

        // Asynchronous reset mid-cycle clears storage and counter at once
        drive_idle();
        bus.rs1_num_i = 3; bus.rs2_num_i = 7;
        #1;
        chk("pre_rst_r3", {32'h0, bus.rs1_data_o}, 64'h55);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_r3", {32'h0, bus.rs1_data_o}, 64'h0);
        chk("async_rst_r7", {32'h0, bus.rs2_data_o}, 64'h0);
        chk("async_rst_retired", {32'h0, retired}, 64'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        bus.v_i = 1; bus.wb_i = 1; bus.rd_num_i = 3; bus.rd_data_i = 32'h77;
        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("post_rst_write_r3", {32'h0, bus.rs1_data_o}, 64'h77);
        chk("post_rst_retired", {32'h0, retired}, 64'h1);

        // Counter wrap on the narrow instance; wb_i=0 accepts leave the register file alone
        bus2.v_i = 1; bus2.wb_i = 0; bus2.rd_num_i = 4; bus2.rd_data_i = 32'h12345678;
        bus2.rs1_num_i = 4;
        repeat (15) @(posedge clk);
        #1;
        chk("wrap_all_ones", {60'h0, retired2}, 64'hF);
        chk("wrap_no_bypass", {32'h0, bus2.rs1_data_o}, 64'h0);
        @(posedge clk); #1;
        chk("wrap_to_zero", {60'h0, retired2}, 64'h0);
        bus2.v_i = 0;
        #1;
        chk("wrap_rf_unchanged", {32'h0, bus2.rs1_data_o}, 64'h0);
        chk("wrap_stall", {63'h0, bus2.stall_o}, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
